pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush statistics counters.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ihit  input  1  instruction fetch completed this cycle.
REQ-005 SHALL have port dmem_req  input  1  EX/MEM latch holds a load or store.
REQ-006 SHALL have port dhit  input  1  data access completed this cycle.
REQ-007 SHALL have port lw_nop  input  1  load-use hazard request from hazard_unit.
REQ-008 SHALL have port jmp_flush  input  1  jump/JR redirect request from hazard_unit.
REQ-009 SHALL have port brch_flush  input  1  taken-branch redirect request from hazard_unit.
REQ-010 SHALL have port halt_in  input  1  HALT instruction present in the MEM/WB latch.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch/PC load enables.
REQ-012 SHALL have ports ifid_flush, idex_flush, exmem_flush  output  1 each  clear latch to a bubble on the next edge.
REQ-013 SHALL have port halt_out  output  1  registered processor-halted indication.
REQ-014 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  registered statistics counters.

Function
REQ-015 SHALL implement states RUN, MEMWAIT, DRAIN, HALTED; encoding is a package enum.
REQ-016 SHALL in any non-HALTED state, when dmem_req=1 and dhit=0 ("mem freeze"), drive all enables 0 and all flushes 0; next state MEMWAIT, or DRAIN if halt_in=1 was seen.
REQ-017 SHALL leave MEMWAIT on the cycle dhit=1; that cycle's outputs follow REQ-019..022; next state RUN.
REQ-018 SHALL apply this priority when not frozen: redirect > load-use > fetch miss > normal.
REQ-019 SHALL on redirect (jmp_flush or brch_flush): pc_en=1, ifid_flush=1, idex_flush=1, all other enables 1; lw_nop ignored.
REQ-020 SHALL on load-use (lw_nop=1, no redirect): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
REQ-021 SHALL on fetch miss (ihit=0, no redirect, no load-use): pc_en=0, ifid_flush=1, remaining enables 1.
REQ-022 SHALL otherwise drive all enables 1 and all flushes 0.
REQ-023 SHALL when halt_in=1 in RUN or MEMWAIT enter DRAIN: pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1 until no mem freeze, then HALTED.
REQ-024 SHALL in HALTED drive all enables and flushes 0 and halt_out=1; HALTED exits only by reset.
REQ-025 SHALL assert halt_out one cycle after entering HALTED (registered).
REQ-026 SHALL increment stall_cnt by 1 on each edge where state is not HALTED and pc_en=0; saturate at all-ones.
REQ-027 SHALL increment flush_cnt by 1 on each edge with a serviced redirect (REQ-019, not frozen); saturate at all-ones.
REQ-028 SHALL hold a redirect arriving during mem freeze unserviced (no count, no flush); hazard_unit keeps the request asserted.

Reset
REQ-029 SHALL, while nRST=0, force state RUN, halt_out=0, stall_cnt=0, flush_cnt=0 asynchronously.
REQ-030 SHALL, while nRST=0, drive all enables and flushes 0 regardless of other inputs.
REQ-031 SHALL return to REQ-022 behaviour on the first edge after nRST deasserts, including from MEMWAIT, DRAIN or HALTED.

Structure
REQ-032 SHALL place the state enum and the CNT_W default in cpu_types_pkg.
REQ-033 SHALL keep the output decode combinational and the state, halt_out and counters in one always_ff.
REQ-034 SHALL instantiate one sub-module, sat_counter, twice for stall_cnt and flush_cnt.

Verification
REQ-035 SHALL check reset: nRST=0 with ihit=1 -> all enables 0, counters 0; release -> all enables 1 next cycle.
REQ-036 SHALL check mem freeze: dmem_req=1, dhit=0 for 3 cycles then dhit=1 -> enables 0 for 3 cycles, 1 on the dhit cycle; stall_cnt=3.
REQ-037 SHALL check priority: lw_nop=1 and brch_flush=1 together -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1.
REQ-038 SHALL check load-use: lw_nop=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt increments by 1.
REQ-039 SHALL check halt: halt_in=1 with dmem_req=1, dhit=0 for 2 cycles -> DRAIN held, then HALTED; halt_out=1 one cycle later and stays 1.
REQ-040 SHALL check saturation: CNT_W=4, 20 consecutive ihit=0 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: FSM state encoding, control bundle
// layout and the default statistics counter width.
package cpu_types_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_IDLE      = 8'b00000_000;
    localparam ctrl_out_t CTRL_NORMAL    = 8'b11111_000;
    localparam ctrl_out_t CTRL_REDIRECT  = 8'b11111_110;
    localparam ctrl_out_t CTRL_LOADUSE   = 8'b00111_010;
    localparam ctrl_out_t CTRL_FETCHMISS = 8'b01111_100;
    localparam ctrl_out_t CTRL_DRAIN     = 8'b00001_111;

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for a saturating up-counter; the register itself lives in
// the instantiating module so all controller state shares one process.
module sat_counter #(
    parameter int W = 16
) (
    input  logic [W-1:0] cnt,
    input  logic         inc,
    output logic [W-1:0] cnt_nxt
);

    // Increment by one unless already at all-ones.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && (cnt != {W{1'b1}})) begin
            cnt_nxt = cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt = cnt;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: arbitrates memory freeze, redirects,
// load-use and fetch-miss stalls, drains on HALT and keeps saturating stats.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             lw_nop,
    input  logic             jmp_flush,
    input  logic             brch_flush,
    input  logic             halt_in,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e      state_r;
    ctrl_state_e      state_nxt_s;
    ctrl_out_t        ctrl_s;
    logic             frozen_s;
    logic             redirect_s;
    logic             redirect_srv_s;
    logic             stall_inc_s;
    logic             halt_out_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] stall_nxt_s;
    logic [CNT_W-1:0] flush_nxt_s;

    assign frozen_s   = dmem_req & ~dhit;
    assign redirect_s = jmp_flush | brch_flush;

    // Next-state and control decode; HALT outranks redirects since it is the oldest instruction.
    always_comb begin
        ctrl_s         = CTRL_IDLE;
        state_nxt_s    = state_r;
        redirect_srv_s = 1'b0;
        case (state_r)
            ST_RUN, ST_MEMWAIT: begin
                if (frozen_s) begin
                    ctrl_s      = CTRL_IDLE;
                    state_nxt_s = halt_in ? ST_DRAIN : ST_MEMWAIT;
                end else if (halt_in) begin
                    ctrl_s      = CTRL_DRAIN;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                    if (redirect_s) begin
                        ctrl_s         = CTRL_REDIRECT;
                        redirect_srv_s = 1'b1;
                    end else if (lw_nop) begin
                        ctrl_s = CTRL_LOADUSE;
                    end else if (!ihit) begin
                        ctrl_s = CTRL_FETCHMISS;
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
            end
            ST_DRAIN: begin
                if (frozen_s) begin
                    ctrl_s      = CTRL_IDLE;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    ctrl_s      = CTRL_DRAIN;
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_HALTED: begin
                ctrl_s      = CTRL_IDLE;
                state_nxt_s = ST_HALTED;
            end
            default: begin
                ctrl_s      = CTRL_IDLE;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign stall_inc_s = (state_r != ST_HALTED) & ~ctrl_s.pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .cnt     (stall_cnt_r),
        .inc     (stall_inc_s),
        .cnt_nxt (stall_nxt_s)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .cnt     (flush_cnt_r),
        .inc     (redirect_srv_s),
        .cnt_nxt (flush_nxt_s)
    );

    // State, halt indication and statistics registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= ST_RUN;
            halt_out_r  <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            halt_out_r  <= (state_r == ST_HALTED);
            stall_cnt_r <= stall_nxt_s;
            flush_cnt_r <= flush_nxt_s;
        end
    end

    // Enables and flushes are forced low for as long as reset is held.
    assign pc_en       = ctrl_s.pc_en       & nRST;
    assign ifid_en     = ctrl_s.ifid_en     & nRST;
    assign idex_en     = ctrl_s.idex_en     & nRST;
    assign exmem_en    = ctrl_s.exmem_en    & nRST;
    assign memwb_en    = ctrl_s.memwb_en    & nRST;
    assign ifid_flush  = ctrl_s.ifid_flush  & nRST;
    assign idex_flush  = ctrl_s.idex_flush  & nRST;
    assign exmem_flush = ctrl_s.exmem_flush & nRST;

    assign halt_out  = halt_out_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: expected control vectors are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_pipeline_ctrl;

    localparam logic [7:0] E_OFF   = 8'b00000_000;
    localparam logic [7:0] E_NORM  = 8'b11111_000;
    localparam logic [7:0] E_REDIR = 8'b11111_110;
    localparam logic [7:0] E_LWNOP = 8'b00111_010;
    localparam logic [7:0] E_FMISS = 8'b01111_100;
    localparam logic [7:0] E_DRAIN = 8'b00001_111;

    // input vector bits: {ihit, dmem_req, dhit, lw_nop, jmp_flush, brch_flush, halt_in}
    localparam logic [6:0] I_NORM = 7'b1000000;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit, dmem_req, dhit, lw_nop, jmp_flush, brch_flush, halt_in;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, halt_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic ifid_flush4, idex_flush4, exmem_flush4, halt_out4;
    logic [3:0] stall_cnt4, flush_cnt4;

    logic [7:0] vec, vec4, e;
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    assign vec  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
    assign vec4 = {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4, idex_flush4, exmem_flush4};

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .lw_nop(lw_nop), .jmp_flush(jmp_flush), .brch_flush(brch_flush), .halt_in(halt_in),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt_out(halt_out), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .lw_nop(lw_nop), .jmp_flush(jmp_flush), .brch_flush(brch_flush), .halt_in(halt_in),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4),
        .memwb_en(memwb_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .exmem_flush(exmem_flush4), .halt_out(halt_out4), .stall_cnt(stall_cnt4),
        .flush_cnt(flush_cnt4)
    );

    // Drive one cycle of inputs, queue its expected controls, wait to the sampling edge.
    task automatic apply(input logic [6:0] in, input logic [7:0] expv);
        {ihit, dmem_req, dhit, lw_nop, jmp_flush, brch_flush, halt_in} = in;
        exp_q.push_back(expv);
        @(negedge CLK);
    endtask

    task automatic step_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        nRST = 1'b0;
        {ihit, dmem_req, dhit, lw_nop, jmp_flush, brch_flush, halt_in} = I_NORM;
        step_edge();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] ins [2] = '{I_NORM, 7'b1001011};
        nRST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(ins[i], E_OFF);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e) begin errors++; $display("FAIL reset_ctrl[%0d]: got %b want %b", i, vec, e); end
            checks++;
            if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || halt_out !== 1'b0) begin
                errors++; $display("FAIL reset_state: stall %0d flush %0d halt %b want 0 0 0", stall_cnt, flush_cnt, halt_out);
            end
            step_edge();
        end
        nRST = 1'b1;
        apply(I_NORM, E_NORM);
        e = exp_q.pop_front();
        checks++;
        if (vec !== e) begin errors++; $display("FAIL reset_release: got %b want %b", vec, e); end
        step_edge();
    endtask

    task automatic test_mem_freeze();
        logic [6:0] ins  [4] = '{7'b1100000, 7'b1100000, 7'b1100000, 7'b1110000};
        logic [7:0] exps [4] = '{E_OFF, E_OFF, E_OFF, E_NORM};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e) begin errors++; $display("FAIL mem_freeze[%0d]: got %b want %b", i, vec, e); end
            step_edge();
        end
        checks++;
        if (stall_cnt !== 16'd3) begin errors++; $display("FAIL mem_freeze_stall: got %0d want 3", stall_cnt); end
        apply(I_NORM, E_NORM);
        e = exp_q.pop_front();
        checks++;
        if (vec !== e) begin errors++; $display("FAIL memwait_exit: got %b want %b", vec, e); end
        step_edge();
    endtask

    task automatic test_priority();
        logic [6:0] ins  [3] = '{7'b1001010, 7'b0000100, 7'b0001000};
        logic [7:0] exps [3] = '{E_REDIR, E_REDIR, E_LWNOP};
        logic [15:0] fl  [3] = '{16'd1, 16'd2, 16'd2};
        logic [15:0] st  [3] = '{16'd0, 16'd0, 16'd1};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            apply(ins[i], exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e) begin errors++; $display("FAIL priority[%0d]: got %b want %b", i, vec, e); end
            step_edge();
            checks++;
            if (flush_cnt !== fl[i] || stall_cnt !== st[i]) begin
                errors++; $display("FAIL priority_cnt[%0d]: flush %0d stall %0d want %0d %0d", i, flush_cnt, stall_cnt, fl[i], st[i]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [6:0] ins  [4] = '{7'b1001000, I_NORM, 7'b0000000, I_NORM};
        logic [7:0] exps [4] = '{E_LWNOP, E_NORM, E_FMISS, E_NORM};
        logic [15:0] st  [4] = '{16'd1, 16'd1, 16'd2, 16'd2};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, vec, e); end
            step_edge();
            checks++;
            if (stall_cnt !== st[i]) begin errors++; $display("FAIL load_use_stall[%0d]: got %0d want %0d", i, stall_cnt, st[i]); end
        end
    endtask

    task automatic test_freeze_redirect();
        logic [6:0] ins  [3] = '{7'b1100010, 7'b1100010, 7'b1110010};
        logic [7:0] exps [3] = '{E_OFF, E_OFF, E_REDIR};
        logic [15:0] fl  [3] = '{16'd0, 16'd0, 16'd1};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            apply(ins[i], exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e) begin errors++; $display("FAIL freeze_redirect[%0d]: got %b want %b", i, vec, e); end
            step_edge();
            checks++;
            if (flush_cnt !== fl[i]) begin errors++; $display("FAIL freeze_redirect_cnt[%0d]: got %0d want %0d", i, flush_cnt, fl[i]); end
        end
        checks++;
        if (stall_cnt !== 16'd2) begin errors++; $display("FAIL freeze_redirect_stall: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_halt();
        logic [6:0] ins  [6] = '{7'b1100001, 7'b1100001, 7'b1110001, I_NORM, 7'b1000010, 7'b0001000};
        logic [7:0] exps [6] = '{E_OFF, E_OFF, E_DRAIN, E_OFF, E_OFF, E_OFF};
        logic       hl   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            apply(ins[i], exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e) begin errors++; $display("FAIL halt_ctrl[%0d]: got %b want %b", i, vec, e); end
            step_edge();
            checks++;
            if (halt_out !== hl[i]) begin errors++; $display("FAIL halt_out[%0d]: got %b want %b", i, halt_out, hl[i]); end
        end
        checks++;
        if (stall_cnt !== 16'd3 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL halt_cnt: stall %0d flush %0d want 3 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_from_halted();
        nRST = 1'b0;
        #1;
        checks++;
        if (halt_out !== 1'b0 || vec !== E_OFF) begin
            errors++; $display("FAIL halted_async_reset: halt %b ctrl %b want 0 %b", halt_out, vec, E_OFF);
        end
        step_edge();
        nRST = 1'b1;
        apply(I_NORM, E_NORM);
        e = exp_q.pop_front();
        checks++;
        if (vec !== e) begin errors++; $display("FAIL halted_release: got %b want %b", vec, e); end
        step_edge();
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            apply(7'b0000000, E_FMISS);
            e = exp_q.pop_front();
            checks++;
            if (vec !== e || vec4 !== e) begin
                errors++; $display("FAIL sat_ctrl[%0d]: got %b/%b want %b", i, vec, vec4, e);
            end
            step_edge();
        end
        checks++;
        if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_stall4: got %0d want 15", stall_cnt4); end
        checks++;
        if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_stall16: got %0d want 20", stall_cnt); end
        checks++;
        if (flush_cnt4 !== 4'd0 || halt_out4 !== 1'b0) begin
            errors++; $display("FAIL sat_other4: flush %0d halt %b want 0 0", flush_cnt4, halt_out4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, want completion");
        $fatal(1);
    end

    initial begin
        {ihit, dmem_req, dhit, lw_nop, jmp_flush, brch_flush, halt_in} = I_NORM;
        test_reset();
        test_mem_freeze();
        test_priority();
        test_load_use();
        test_freeze_redirect();
        test_halt();
        test_reset_from_halted();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
